// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Desc     : Shared VGA timing constants and sync-receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } rx_state_t;

    // 640x400 @ 70 Hz; horizontal in pixel clocks, vertical in lines
    localparam int unsigned c_vga_hact   = 640;
    localparam int unsigned c_vga_hfp    = 16;
    localparam int unsigned c_vga_hsw    = 96;
    localparam int unsigned c_vga_hbp    = 48;
    localparam int unsigned c_vga_htotal = c_vga_hact + c_vga_hfp + c_vga_hsw + c_vga_hbp;
    localparam int unsigned c_vga_vact   = 400;
    localparam int unsigned c_vga_vfp    = 12;
    localparam int unsigned c_vga_vsw    = 2;
    localparam int unsigned c_vga_vbp    = 35;
    localparam int unsigned c_vga_vtotal = c_vga_vact + c_vga_vfp + c_vga_vsw + c_vga_vbp;

    function automatic logic in_range(input logic [11:0] pos,
                                      input logic [11:0] lo,
                                      input logic [11:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_edge_meter.sv
`default_nettype none
// ============================================================================
// Module   : vga_edge_meter
// Desc     : Samples one normalised sync (1 = sync level) on each enable strobe,
//            flags the sync-to-inactive edge and measures period and pulse width.
// Revision : 1.0 - initial release
// ============================================================================
module vga_edge_meter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_sync,
    output logic         o_edge,
    output logic [W-1:0] o_pos,
    output logic         o_sat,
    output logic [W-1:0] o_period_now,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_width
);

    localparam logic [W-1:0] c_max = {W{1'b1}};

    logic         r_prev;
    logic [W-1:0] r_pos;
    logic [W-1:0] r_wcnt;
    logic [W-1:0] w_pos_inc;
    logic [W-1:0] w_wcnt_inc;

    assign w_pos_inc  = (r_pos  == c_max) ? c_max : r_pos  + W'(1);
    assign w_wcnt_inc = (r_wcnt == c_max) ? c_max : r_wcnt + W'(1);

    assign o_edge       = i_en & r_prev & ~i_sync;
    assign o_period_now = w_pos_inc;

    // Position of the current cycle: the edge strobe is 0, later strobes count
    // up, and between strobes the last strobe's position is held.
    always_comb begin
        o_pos = r_pos;
        if (i_en) begin
            o_pos = o_edge ? '0 : w_pos_inc;
        end
    end

    assign o_sat = (o_pos == c_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev   <= 1'b0;
            r_pos    <= '0;
            r_wcnt   <= '0;
            o_period <= '0;
            o_width  <= '0;
        end else if (i_en) begin
            r_prev <= i_sync;
            r_pos  <= o_pos;
            r_wcnt <= i_sync ? w_wcnt_inc : '0;
            if (o_edge) begin
                o_period <= w_pos_inc;
                o_width  <= r_wcnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_rx
// Desc     : VGA sync receiver; measures hs/vs geometry, locks onto a stable
//            mode and regenerates beam position and the data-enable window.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_rx
    import vga_pkg::*;
#(
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b1,
    parameter int unsigned HBP    = c_vga_hbp,
    parameter int unsigned HACT   = c_vga_hact,
    parameter int unsigned VBP    = c_vga_vbp,
    parameter int unsigned VACT   = c_vga_vact
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        locked,
    output logic        frame_start,
    output logic [11:0] htotal,
    output logic [11:0] hsw,
    output logic [10:0] vtotal,
    output logic [10:0] vsw
);

    localparam logic [11:0] c_hbp  = 12'(HBP);
    localparam logic [11:0] c_hend = 12'(HBP + HACT);
    localparam logic [10:0] c_vbp  = 11'(VBP);
    localparam logic [10:0] c_vend = 11'(VBP + VACT);

    logic        w_hsync;
    logic        w_vsync;
    logic        w_hedge;
    logic        w_vedge;
    logic [11:0] w_hpos;
    logic [10:0] w_vpos;
    logic        w_hsat;
    logic        w_vsat;
    logic [11:0] w_htotal_now;
    logic [10:0] w_vtotal_now;

    assign w_hsync = (hs == HS_POL);
    assign w_vsync = (vs == VS_POL);

    vga_edge_meter #(.W(12)) u_hmeter (
        .clk          (clock),
        .rst          (reset),
        .i_en         (1'b1),
        .i_sync       (w_hsync),
        .o_edge       (w_hedge),
        .o_pos        (w_hpos),
        .o_sat        (w_hsat),
        .o_period_now (w_htotal_now),
        .o_period     (htotal),
        .o_width      (hsw)
    );

    // vs is only looked at on line starts, so its edge is a frame start
    vga_edge_meter #(.W(11)) u_vmeter (
        .clk          (clock),
        .rst          (reset),
        .i_en         (w_hedge),
        .i_sync       (w_vsync),
        .o_edge       (w_vedge),
        .o_pos        (w_vpos),
        .o_sat        (w_vsat),
        .o_period_now (w_vtotal_now),
        .o_period     (vtotal),
        .o_width      (vsw)
    );

    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [11:0] r_href;
    logic        r_href_valid;
    logic [10:0] r_vref;
    logic        w_line_bad;
    logic        w_sat;
    logic        w_lock_next;
    logic        w_in_win;

    assign w_line_bad = w_hedge & r_href_valid & (w_htotal_now != r_href);
    assign w_sat      = w_hsat | w_vsat;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH: begin
                if (!w_sat && w_vedge) w_state_next = TRACK;
            end
            TRACK: begin
                if (w_sat || w_line_bad) w_state_next = SEARCH;
                else if (w_vedge)        w_state_next = CHECK;
            end
            CHECK: begin
                if (w_sat || w_line_bad) w_state_next = SEARCH;
                else if (w_vedge)        w_state_next = (w_vtotal_now == r_vref) ? LOCKED : SEARCH;
            end
            LOCKED: begin
                if (w_sat || w_line_bad || (w_vedge && (w_vtotal_now != r_vref)))
                    w_state_next = SEARCH;
            end
            default: w_state_next = SEARCH;
        endcase
    end

    // Line reference comes from the first full line after entering TRACK
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= SEARCH;
            r_href       <= '0;
            r_href_valid <= 1'b0;
            r_vref       <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == SEARCH) begin
                r_href_valid <= 1'b0;
            end else if ((r_state == TRACK) && w_hedge && !r_href_valid) begin
                r_href       <= w_htotal_now;
                r_href_valid <= 1'b1;
            end
            if ((r_state == TRACK) && w_vedge) begin
                r_vref <= w_vtotal_now;
            end
        end
    end

    // Using the next state lets locked and de fall together on a bad line
    assign w_lock_next = (w_state_next == LOCKED);
    assign w_in_win    = w_lock_next
                       && in_range(w_hpos, c_hbp, c_hend)
                       && in_range({1'b0, w_vpos}, {1'b0, c_vbp}, {1'b0, c_vend});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= w_in_win;
            x           <= w_in_win ? 10'(w_hpos - c_hbp) : '0;
            y           <= w_in_win ? 10'(w_vpos - c_vbp) : '0;
            locked      <= w_lock_next;
            frame_start <= w_vedge;
        end
    end

endmodule
`default_nettype wire
